// File: rtl/hex_keypad_scanner_pkg.sv
// Shared types for the hex keypad scanner: FSM states, frame classes, key codes
// and the frame classification helpers.
package kpd_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef logic [3:0] key_code_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_DEB = 2'd1,
    HELD      = 2'd2,
    REL_DEB   = 2'd3
  } kpd_state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } frame_class_t;

  // A frame is one bit per key, indexed row*4 + col.
  function automatic frame_class_t classify(input logic [NUM_ROWS*NUM_COLS-1:0] bits);
    logic [4:0]   n;
    frame_class_t cls;
    n = 5'd0;
    for (int i = 0; i < NUM_ROWS*NUM_COLS; i++) begin
      n = n + {4'd0, bits[i]};
    end
    case (n)
      5'd0:    cls = NONE;
      5'd1:    cls = SINGLE;
      default: cls = MULTI;
    endcase
    return cls;
  endfunction

  function automatic key_code_t first_key(input logic [NUM_ROWS*NUM_COLS-1:0] bits);
    key_code_t k;
    k = 4'd0;
    for (int i = 0; i < NUM_ROWS*NUM_COLS; i++) begin
      if (bits[i]) begin
        k = key_code_t'(i);
      end
    end
    return k;
  endfunction

endpackage

// File: rtl/hex_keypad_scanner_if.sv
// Keypad matrix lines plus the key delivery handshake; master is the scanner,
// slave is the keypad/consumer side.
interface hex_keypad_scanner_if;
  import kpd_pkg::*;

  logic [3:0]  rows;
  logic [3:0]  cols;
  key_code_t   keyCode;
  logic        keyValid;
  logic        keyAck;
  logic        keyDown;
  logic        overflow;
  logic [31:0] entry;
  logic        clearEntry;

  modport master (
    input  rows, keyAck, clearEntry,
    output cols, keyCode, keyValid, keyDown, overflow, entry
  );

  modport slave (
    output rows, keyAck, clearEntry,
    input  cols, keyCode, keyValid, keyDown, overflow, entry
  );

endinterface

// File: rtl/hex_keypad_scanner_row_sync.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
module kpd_row_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] din,
  output logic [3:0] dout
);

  logic [3:0] meta_r;
  logic [3:0] sync_r;

  // metastability stage followed by the stable stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 4'd0;
      sync_r <= 4'd0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
    end
  end

  assign dout = sync_r;

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: column strobing, frame-based debounce, valid/ack key
// delivery and an eight-digit entry shift register.
module hex_keypad_scanner
  import kpd_pkg::*;
#(
  parameter int COL_CYCLES      = 4,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic                 scanClk,
  input  logic                 rstN,
  hex_keypad_scanner_if.master kpd
);

  localparam logic [3:0] PHASE_LAST = 4'(COL_CYCLES - 1);
  localparam logic [3:0] DEB_LAST   = 4'(DEBOUNCE_FRAMES);

  logic [3:0]   rows_sync_s;
  logic [3:0]   phase_r;
  logic [1:0]   col_idx_r;
  logic [3:0]   cols_r;
  logic [15:0]  frame_bits_r;
  logic [15:0]  frame_next_s;
  logic         phase_last_s;
  logic         frame_end_s;
  frame_class_t cls_s;
  key_code_t    key_s;

  kpd_state_t   state_r;
  logic [3:0]   cnt_r;
  key_code_t    cand_r;
  logic         accept_r;
  logic         key_down_r;

  key_code_t    key_code_r;
  logic         key_valid_r;
  logic         overflow_r;
  logic [31:0]  entry_r;

  kpd_row_sync u_row_sync (
    .clk   (scanClk),
    .rst_n (rstN),
    .din   (kpd.rows),
    .dout  (rows_sync_s)
  );

  assign phase_last_s = (phase_r == PHASE_LAST);
  assign frame_end_s  = phase_last_s && (col_idx_r == 2'd3);

  // Current frame with the active column's rows merged in; at frame end this
  // is the complete 16-key snapshot.
  always_comb begin
    frame_next_s = frame_bits_r;
    for (int r = 0; r < NUM_ROWS; r++) begin
      frame_next_s[{2'(r), col_idx_r}] = rows_sync_s[r];
    end
  end

  assign cls_s = classify(frame_next_s);
  assign key_s = first_key(frame_next_s);

  // column strobe rotation and per-column row capture
  always_ff @(posedge scanClk or negedge rstN) begin
    if (!rstN) begin
      phase_r      <= 4'd0;
      col_idx_r    <= 2'd0;
      cols_r       <= 4'b0001;
      frame_bits_r <= 16'd0;
    end else if (phase_last_s) begin
      phase_r      <= 4'd0;
      col_idx_r    <= col_idx_r + 2'd1;
      cols_r       <= {cols_r[2:0], cols_r[3]};
      frame_bits_r <= frame_next_s;
    end else begin
      phase_r      <= phase_r + 4'd1;
    end
  end

  // press/release debounce FSM, stepped once per frame
  always_ff @(posedge scanClk or negedge rstN) begin
    if (!rstN) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      cand_r     <= 4'd0;
      accept_r   <= 1'b0;
      key_down_r <= 1'b0;
    end else begin
      accept_r <= 1'b0;
      if (frame_end_s) begin
        case (state_r)
          IDLE: begin
            if (cls_s == SINGLE) begin
              state_r <= PRESS_DEB;
              cand_r  <= key_s;
              cnt_r   <= 4'd1;
            end else begin
              state_r <= IDLE;
            end
          end
          PRESS_DEB: begin
            if ((cls_s == SINGLE) && (key_s == cand_r)) begin
              if ((cnt_r + 4'd1) == DEB_LAST) begin
                state_r    <= HELD;
                key_down_r <= 1'b1;
                accept_r   <= 1'b1;
              end else begin
                cnt_r <= cnt_r + 4'd1;
              end
            end else begin
              state_r <= IDLE;
            end
          end
          HELD: begin
            // no rollover: a second key is ignored until everything is released
            if (cls_s == NONE) begin
              state_r <= REL_DEB;
              cnt_r   <= 4'd1;
            end else begin
              state_r <= HELD;
            end
          end
          REL_DEB: begin
            if (cls_s == NONE) begin
              if ((cnt_r + 4'd1) == DEB_LAST) begin
                state_r    <= IDLE;
                key_down_r <= 1'b0;
              end else begin
                cnt_r <= cnt_r + 4'd1;
              end
            end else begin
              state_r <= HELD;
            end
          end
          default: begin
            state_r    <= IDLE;
            key_down_r <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  // key delivery handshake, overflow flag and entry shift register
  always_ff @(posedge scanClk or negedge rstN) begin
    if (!rstN) begin
      key_code_r  <= 4'd0;
      key_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
      entry_r     <= 32'd0;
    end else begin
      if (accept_r) begin
        if (!key_valid_r || kpd.keyAck) begin
          key_code_r  <= cand_r;
          key_valid_r <= 1'b1;
        end else begin
          overflow_r  <= 1'b1;
        end
      end else if (kpd.keyAck) begin
        key_valid_r <= 1'b0;
      end else begin
        key_valid_r <= key_valid_r;
      end

      if (kpd.clearEntry) begin
        entry_r    <= accept_r ? {28'd0, cand_r} : 32'd0;
        overflow_r <= 1'b0;
      end else if (accept_r) begin
        entry_r    <= {entry_r[27:0], cand_r};
      end else begin
        entry_r    <= entry_r;
      end
    end
  end

  assign kpd.cols     = cols_r;
  assign kpd.keyCode  = key_code_r;
  assign kpd.keyValid = key_valid_r;
  assign kpd.keyDown  = key_down_r;
  assign kpd.overflow = overflow_r;
  assign kpd.entry    = entry_r;

endmodule

// File: doc/hex_keypad_scanner.md
Name: hex_keypad_scanner

Overview:
Scans a 4x4 matrix hex keypad by driving one-hot column strobes and sampling the row lines. It debounces each press and release over whole scan frames. Each debounced press becomes a 4-bit key code delivered on a valid/ack handshake, and is also shifted into a 32-bit entry register. The entry register feeds the board's hex seven-segment display path, making this block the input-side counterpart of the display multiplexer.

Parameters:
COL_CYCLES, 4, clock cycles each column strobe is held; legal range 3..15 (covers the 2-cycle row synchronizer latency)
DEBOUNCE_FRAMES, 3, consecutive identical scan frames needed to accept a press or a release; legal range 2..15

Ports:
scanClk  input  1  scan clock; all state changes on rising edge
rstN  input  1  reset, asynchronous, active-low
rows  input  4  raw keypad row lines, active-high, asynchronous to scanClk
cols  output  4  one-hot column strobe, active-high
keyCode  output  4  code of the last accepted key: row*4 + col
keyValid  output  1  high while an accepted key is waiting for keyAck
keyAck  input  1  consumer acknowledge; clears keyValid
keyDown  output  1  high while the debounced key is held
overflow  output  1  sticky: a press was accepted while keyValid was still pending
entry  output  32  last eight accepted codes; newest in [3:0]
clearEntry  input  1  synchronous clear of entry and overflow

Behaviour:
- Reset (rstN low, takes effect immediately): cols=4'b0001, keyCode=0, keyValid=0, keyDown=0, overflow=0, entry=0, FSM=IDLE, phase and debounce counters=0, synchronizer flops=0. Asserting reset mid-frame or mid-debounce discards all partial state.
- Row synchronizer: rows passes through 2 flops before use.
- Column scan: a phase counter counts 0..COL_CYCLES-1. On wrap, cols rotates {cols[2:0],cols[3]}. The synchronized rows are captured in the last phase cycle of each column.
- Frame: 4 columns, i.e. 4*COL_CYCLES cycles. At frame end, the 16 captured bits classify the frame:
  - NONE: 0 bits set.
  - SINGLE(k): exactly 1 bit set; k = row*4 + col.
  - MULTI: 2 or more bits set.
- FSM transitions, evaluated once per frame end:
  - IDLE: SINGLE(k) -> PRESS_DEB, cand=k, cnt=1. Anything else -> stay.
  - PRESS_DEB: SINGLE(cand) -> cnt+1; on reaching DEBOUNCE_FRAMES -> HELD and accept the press. NONE, MULTI or SINGLE(other) -> IDLE.
  - HELD: keyDown=1. NONE -> REL_DEB, cnt=1. SINGLE(any) or MULTI -> stay. There is no rollover; the key must be released first.
  - REL_DEB: keyDown stays 1. NONE -> cnt+1; on reaching DEBOUNCE_FRAMES -> IDLE and keyDown=0. Any press -> HELD.
- Accept, registered in the cycle after the frame-end edge:
  - entry <= {entry[27:0], cand}. entry shifts on every accepted press, regardless of the handshake.
  - If keyValid=0, or keyAck=1 in the same cycle: keyCode<=cand, keyValid<=1.
  - If keyValid=1 and keyAck=0: keyCode is unchanged and overflow<=1.
- keyAck with keyValid=1 and no accept in that cycle: keyValid<=0. keyAck with keyValid=0 is ignored.
- clearEntry: entry<=0 and overflow<=0. If an accept occurs in the same cycle, entry<={28'b0,cand}.
- Latency: for a key stable from a frame boundary, keyValid rises DEBOUNCE_FRAMES*4*COL_CYCLES+1 cycles later.

Decomposition:
- Package kpd_pkg holds:
  - enum kpd_state_t {IDLE, PRESS_DEB, HELD, REL_DEB}
  - typedef key_code_t (logic[3:0])
  - NUM_ROWS=4 and NUM_COLS=4
  - enum frame_class_t {NONE, SINGLE, MULTI}
- Sub-module kpd_row_sync: 4-bit 2-flop synchronizer with async active-low reset.

Test Plan:
All scenarios use COL_CYCLES=4 and DEBOUNCE_FRAMES=3, so one frame is 16 cycles.
1. Reset and scan: release rstN -> cols is 0001 for 4 cycles, then 0010, 0100, 1000, 0001. Pull rstN low mid-frame -> cols=0001, entry=0 immediately, with no clock.
2. Clean press: rows=4'b0100 whenever cols=0010 (key 9) from a frame boundary -> at cycle 49: keyValid=1, keyCode=4'h9, keyDown=1, entry=32'h00000009. Pulse keyAck -> keyValid=0 next cycle. Release for 3 frames -> keyDown=0.
3. Bounce: key 9 held for 2 frames, then 1 NONE frame, then held again -> no keyValid during the first attempt; the debounce restarts, and keyValid rises 3 frames after the re-press.
4. Multi-key: keys 0 and 5 held together for 5 frames -> no event. Release key 0 -> key 5 accepted 3 frames later; keyCode=4'h5.
5. Overflow: accept key 1 without ack, release it, then accept key 2 -> keyCode=4'h1, overflow=1, entry=32'h00000012. clearEntry -> entry=0, overflow=0, keyValid still 1.
6. Coincidence: keyAck and an accept of key A in the same cycle -> keyValid=1, keyCode=4'hA, overflow=0. clearEntry coincident with an accept of key C -> entry=32'h0000000C.
